// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer: accepts one shift command per handshake, applies one
// single-bit shift per clock, and presents the result on a valid/ready output.
// Optional feature macro: SHIFT_ROTATE_EN adds the in_rot port and rotate steps.
module shift_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [CNT_W-1:0] in_count,
`ifdef SHIFT_ROTATE_EN
  input  logic             in_rot,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             rot_q;
  logic [WIDTH-1:0] step_w;

  // One 1-bit step; the vacated bit is zero unless rotating.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic dir,
                                                  input logic rot);
    logic fill;
    if (dir) begin
      fill = rot & d[WIDTH-1];
      return {d[WIDTH-2:0], fill};
    end else begin
      fill = rot & d[0];
      return {fill, d[WIDTH-1:1]};
    end
  endfunction

`ifdef SHIFT_ROTATE_EN
  logic rot_d;

  // Rotate select captured with the command so later in_rot changes are ignored.
  always_comb begin
    rot_d = rot_q;
    if (state_q == IDLE && in_valid) rot_d = in_rot;
  end

  // Rotate select register (payload, not reset).
  always_ff @(posedge clk) begin
    rot_q <= rot_d;
  end
`else
  assign rot_q = 1'b0;
`endif

  assign step_w = shift_step(data_q, dir_q, rot_q);

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    dir_d      = dir_q;
    rem_d      = rem_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          dir_d  = in_dir;
          rem_d  = in_count;
          if (in_count == '0) begin
            // Zero-step command goes straight to DONE with the word unchanged.
            state_d    = DONE;
            out_data_d = in_data;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d = step_w;
        rem_d  = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) begin
          // Result captured separately so it survives the next accept.
          state_d    = DONE;
          out_data_d = step_w;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible result registers; reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      out_data_q <= out_data_d;
    end
  end

  // Working word and direction (payload, not reset).
  always_ff @(posedge clk) begin
    data_q <= data_d;
    dir_q  <= dir_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;

endmodule
